x_uart_rx_cfg: RTL and testbench
================================

Name: x_uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Adds configurable data width, optional odd/even parity, one or two stop bits, false-start rejection, framing/parity error flags and line-break detection. Sits between an async pin and a synchronous consumer. Emits one registered result pulse per frame; there is no backpressure.

Parameters:
p_clk_hz, 1200000, system clock frequency in Hz
p_baud, 115200, line baud rate; bit period P = p_clk_hz/p_baud (integer divide), must be >= 4
p_data_bits, 8, data bits per frame, legal 5..9
p_parity, 0, 0 = none, 1 = odd, 2 = even
p_stop_bits, 1, legal 1 or 2

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_rx  input  1  async serial line, idle high
o_valid  output  1  one-cycle pulse: frame complete, data and flags valid this cycle
o_data  output  p_data_bits  received word, LSB first on line; holds until next o_valid
o_parity_err  output  1  parity mismatch; meaningful only while o_valid=1
o_frame_err  output  1  any stop sample low; meaningful only while o_valid=1
o_break  output  1  break frame; meaningful only while o_valid=1

Behaviour:
- Reset: all flops asynchronous on i_rst_n low. o_valid=0, o_data=0, all error flags 0. State = IDLE, timer = 0, bit counter = 0, sync flops = 1.
- Reset mid-frame aborts the frame with no o_valid. After release, the receiver needs a fresh high->low edge.
- Sync: two flops then one edge-detect flop. The fall event F is the cycle in which sync output is 0 and the delayed copy is 1.
- Timer: counts 0..P-1 and wraps. It is enabled only outside IDLE. It clears to 0 on the cycle F is taken.
- Bit counter: width $clog2(p_data_bits+1).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on F.
- START: sample when timer == P/2-1, i.e. the mid start bit, P/2 cycles after F. If the sample is 1, it is a false start: go to IDLE with no output. If 0, restart the timer and go to DATA.
- DATA: sample at each timer == P-1. Shift the sample into the MSB of the shift register and count bits. After p_data_bits samples go to PARITY if p_parity != 0, else STOP.
- PARITY: one sample at timer == P-1.
  - Expected bit, even mode: XOR of the data bits.
  - Expected bit, odd mode: inverse of that XOR.
  - Mismatch latches the parity error.
- STOP: one sample per stop bit at timer == P-1. Any 0 latches the frame error. After the last stop sample go to IDLE at once, so the next start edge can be accepted within half a stop bit.
- Output, cycle after the last stop sample:
  - o_valid=1 for exactly one cycle.
  - o_data loads from the shift register.
  - Flags register at the same time.
- Break: all data samples 0, parity sample 0 (if present) and every stop sample 0. Asserts o_break=1 and o_frame_err=1 together.
- After any frame ending with the line low, nothing further is received until the line goes high and falls again. This follows from the edge-based start detection.
- Error flags are per frame and are cleared at START entry.
- o_data is not altered by errors: data is always delivered.
- No FIFO: a frame completing before the consumer reads simply overwrites o_data.
- Edge events outside IDLE are ignored. There is no resync within a frame.

Test Plan:
- Default params (P=10), send 8N1 0xA5 with correct stop. Require one o_valid pulse, o_data=0xA5, all flags 0. Pulse occurs 5+8*10+10+1 = 96 cycles after F.
- p_parity=2: send 0x03 with parity bit 0 -> o_valid, o_parity_err=0. Resend with parity bit 1 -> o_data=0x03, o_parity_err=1, o_frame_err=0.
- Send 0x5A with stop bit driven 0 -> o_data=0x5A, o_frame_err=1, o_break=0.
- Glitch: i_rx low for 3 cycles then high -> no o_valid. Then send 0x11 -> o_data=0x11 with no errors.
- Break: i_rx held low for 20 bit times -> exactly one o_valid with o_data=0, o_break=1, o_frame_err=1. No further o_valid until i_rx returns high. Then send 0x7E -> o_data=0x7E.
- Two configurations:
  - p_data_bits=5, p_stop_bits=2: send 0x15 back-to-back twice -> two pulses, o_data=0x15 each.
  - Reset mid-frame: assert i_rst_n=0 in bit 3 -> all outputs 0, no o_valid. A following frame 0x0A is received correctly.

Source files
------------

// File: rtl/x_uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1-2 stops,
// false-start rejection, framing/parity error and line-break flags.
module x_uart_rx_cfg #(
  parameter int p_clk_hz    = 1200000,
  parameter int p_baud      = 115200,
  parameter int p_data_bits = 8,
  parameter int p_parity    = 0,
  parameter int p_stop_bits = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_rx,
  output logic                   o_valid,
  output logic [p_data_bits-1:0] o_data,
  output logic                   o_parity_err,
  output logic                   o_frame_err,
  output logic                   o_break
);

  localparam int LP_P  = p_clk_hz / p_baud;
  localparam int LP_TW = $clog2(LP_P);
  localparam int LP_CW = $clog2(p_data_bits + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic [LP_TW-1:0] r_timer;
  logic [LP_CW-1:0] r_cnt;
  logic [p_data_bits-1:0] r_shift;
  logic r_par;
  logic r_perr;
  logic r_ferr;
  logic r_any1;

  logic r_valid;
  logic [p_data_bits-1:0] r_data;
  logic r_perr_o;
  logic r_ferr_o;
  logic r_brk_o;

  logic w_fall;
  logic w_mid;
  logic w_end;
  logic w_last_data;
  logic w_last_stop;
  logic w_pexp;
  logic w_tclr;
  logic w_start;
  logic w_shift;
  logic w_psamp;
  logic w_ssamp;
  logic w_done;

  assign w_fall      = r_s3 & ~r_s2;
  assign w_mid       = r_timer == LP_TW'(LP_P / 2 - 1);
  assign w_end       = r_timer == LP_TW'(LP_P - 1);
  assign w_last_data = r_cnt == LP_CW'(p_data_bits - 1);
  assign w_last_stop = r_cnt == LP_CW'(p_stop_bits - 1);
  assign w_pexp      = (p_parity == 1) ? ~r_par : r_par;

  always_comb begin
    w_next  = r_state;
    w_tclr  = 1'b0;
    w_start = 1'b0;
    w_shift = 1'b0;
    w_psamp = 1'b0;
    w_ssamp = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_next  = S_START;
          w_tclr  = 1'b1;
          w_start = 1'b1;
        end
      end
      S_START: begin
        if (w_mid) begin
          if (r_s2) begin
            w_next = S_IDLE;
          end else begin
            w_next = S_DATA;
            w_tclr = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_end) begin
          w_shift = 1'b1;
          if (w_last_data) begin
            w_next = (p_parity != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (w_end) begin
          w_psamp = 1'b1;
          w_next  = S_STOP;
        end
      end
      S_STOP: begin
        if (w_end) begin
          w_ssamp = 1'b1;
          if (w_last_stop) begin
            w_done = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_rx;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (w_tclr) begin
      r_timer <= '0;
    end else if (r_state != S_IDLE) begin
      r_timer <= w_end ? '0 : r_timer + LP_TW'(1);
    end
  end

  // one counter serves data bits, then is reused for stop bits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= w_last_data ? '0 : r_cnt + LP_CW'(1);
    end else if (w_ssamp) begin
      r_cnt <= r_cnt + LP_CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_any1  <= 1'b0;
    end else if (w_start) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_any1 <= 1'b0;
    end else if (w_shift) begin
      r_shift <= {r_s2, r_shift[p_data_bits-1:1]};
      r_par   <= r_par ^ r_s2;
      r_any1  <= r_any1 | r_s2;
    end else if (w_psamp) begin
      r_perr <= r_s2 != w_pexp;
      r_any1 <= r_any1 | r_s2;
    end else if (w_ssamp) begin
      r_ferr <= r_ferr | ~r_s2;
      r_any1 <= r_any1 | r_s2;
    end
  end

  // final stop sample folds straight into the registered flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
      r_brk_o  <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_data   <= r_shift;
        r_perr_o <= r_perr;
        r_ferr_o <= r_ferr | ~r_s2;
        r_brk_o  <= ~(r_any1 | r_s2);
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_data       = r_data;
  assign o_parity_err = r_perr_o;
  assign o_frame_err  = r_ferr_o;
  assign o_break      = r_brk_o;

endmodule

// File: tb/tb_x_uart_rx_cfg.sv
// Bench for x_uart_rx_cfg: three configurations checked against
// a frame-level model of expected results and pulse timing.
module tb_x_uart_rx_cfg;

  localparam int P = 1200000 / 115200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n;
  logic [2:0] rx;
  logic [2:0] v;
  logic [2:0] pe;
  logic [2:0] fe;
  logic [2:0] bk;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [4:0] d2;
  logic [8:0] dd [3];

  assign dd[0] = {1'b0, d0};
  assign dd[1] = {1'b0, d1};
  assign dd[2] = {4'b0, d2};

  x_uart_rx_cfg u0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_rx(rx[0]),
    .o_valid(v[0]), .o_data(d0), .o_parity_err(pe[0]),
    .o_frame_err(fe[0]), .o_break(bk[0])
  );

  x_uart_rx_cfg #(.p_parity(2)) u1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_rx(rx[1]),
    .o_valid(v[1]), .o_data(d1), .o_parity_err(pe[1]),
    .o_frame_err(fe[1]), .o_break(bk[1])
  );

  x_uart_rx_cfg #(.p_data_bits(5), .p_stop_bits(2)) u2 (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_rx(rx[2]),
    .o_valid(v[2]), .o_data(d2), .o_parity_err(pe[2]),
    .o_frame_err(fe[2]), .o_break(bk[2])
  );

  typedef struct {
    int       id;
    longint   cyc;
    logic [8:0] data;
    logic     perr;
    logic     ferr;
    logic     brk;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  longint cyc = 0;
  longint lastv [3];
  logic [8:0] ld [3];
  logic lpe [3];
  logic lfe [3];
  logic lbk [3];
  int nv [3] = '{default: 0};

  function automatic int nb(input int id);
    return (id == 2) ? 5 : 8;
  endfunction

  function automatic int npar(input int id);
    return (id == 1) ? 1 : 0;
  endfunction

  function automatic int nst(input int id);
    return (id == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // frame outcome from what was put on the line, plus its pulse cycle
  task automatic push_exp(input int id, input longint n, input logic [8:0] data,
                          input logic pb, input logic s0, input logic s1);
    exp_t e;
    logic [8:0] m;
    m = data & 9'((1 << nb(id)) - 1);
    e.id   = id;
    e.data = m;
    e.perr = (npar(id) == 1) ? (pb != ^m) : 1'b0;
    e.ferr = !s0 || (nst(id) == 2 && !s1);
    e.brk  = (m == 0) && (npar(id) == 0 || !pb) && !s0 && (nst(id) == 1 || !s1);
    e.cyc  = n + 2 + P / 2 + (nb(id) + npar(id) + nst(id)) * P + 1;
    q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (v[i]) begin
        nv[i]++;
        lastv[i] = cyc;
        ld[i] = dd[i];
        lpe[i] = pe[i];
        lfe[i] = fe[i];
        lbk[i] = bk[i];
        if (q.size() == 0) begin
          chk($sformatf("spurious_valid_u%0d", i), 1, 0);
        end else begin
          e = q.pop_front();
          chk("valid_inst", i, e.id);
          chk("valid_cycle", cyc, e.cyc);
          chk("data", dd[i], e.data);
          chk("parity_err", pe[i], e.perr);
          chk("frame_err", fe[i], e.ferr);
          chk("break", bk[i], e.brk);
        end
      end
    end
    if (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missed_valid", cyc, q[0].cyc);
      void'(q.pop_front());
    end
  end

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input logic [8:0] data, input logic pb,
                      input logic s0, input logic s1, input int gap,
                      output longint n);
    rx[id] = 1'b0;
    n = cyc;
    push_exp(id, n, data, pb, s0, s1);
    idle(P);
    for (int i = 0; i < nb(id); i++) begin
      rx[id] = data[i];
      idle(P);
    end
    if (npar(id) == 1) begin
      rx[id] = pb;
      idle(P);
    end
    rx[id] = s0;
    idle(P);
    if (nst(id) == 2) begin
      rx[id] = s1;
      idle(P);
    end
    rx[id] = 1'b1;
    if (gap > 0) idle(gap);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() > 0 && k < 1000) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    longint n;
    int k;
    int gap;
    logic [8:0] dat;
    logic pb;
    logic s0;
    logic s1;
    logic last_stop;

    rx = '1;
    rst_n = '1;
    #1 rst_n = '0;
    #2;
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_u%0d", i), {v[i], dd[i], pe[i], fe[i], bk[i]}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = '1;
    idle(5);

    send(0, 9'h0A5, 1'b0, 1'b1, 1'b1, 20, n);
    drain();
    chk("a5_latency_from_fall", lastv[0] - (n + 2), 96);
    chk("a5_data", ld[0], 9'h0A5);
    chk("a5_flags", {lpe[0], lfe[0], lbk[0]}, 0);

    send(1, 9'h003, 1'b0, 1'b1, 1'b1, 20, n);
    drain();
    chk("p03_good_perr", lpe[1], 0);
    send(1, 9'h003, 1'b1, 1'b1, 1'b1, 20, n);
    drain();
    chk("p03_bad_perr", lpe[1], 1);
    chk("p03_bad_data", ld[1], 9'h003);
    chk("p03_bad_ferr", lfe[1], 0);

    send(0, 9'h05A, 1'b0, 1'b0, 1'b1, 20, n);
    drain();
    chk("5a_data", ld[0], 9'h05A);
    chk("5a_ferr", lfe[0], 1);
    chk("5a_break", lbk[0], 0);

    k = nv[0];
    rx[0] = 1'b0;
    idle(3);
    rx[0] = 1'b1;
    idle(40);
    chk("glitch_no_valid", nv[0], k);
    send(0, 9'h011, 1'b0, 1'b1, 1'b1, 20, n);
    drain();
    chk("11_data", ld[0], 9'h011);
    chk("11_flags", {lpe[0], lfe[0], lbk[0]}, 0);

    k = nv[0];
    rx[0] = 1'b0;
    n = cyc;
    push_exp(0, n, 9'h000, 1'b0, 1'b0, 1'b0);
    idle(20 * P);
    chk("break_one_pulse", nv[0], k + 1);
    chk("break_flag", lbk[0], 1);
    chk("break_ferr", lfe[0], 1);
    chk("break_data", ld[0], 0);
    rx[0] = 1'b1;
    idle(20);
    send(0, 9'h07E, 1'b0, 1'b1, 1'b1, 20, n);
    drain();
    chk("7e_data", ld[0], 9'h07E);

    k = nv[2];
    send(2, 9'h015, 1'b0, 1'b1, 1'b1, 0, n);
    send(2, 9'h015, 1'b0, 1'b1, 1'b1, 20, n);
    drain();
    chk("b2b_count", nv[2], k + 2);
    chk("b2b_data", ld[2], 9'h015);

    k = nv[2];
    rx[2] = 1'b0;
    idle(4 * P + 3);
    rst_n[2] = 1'b0;
    rx[2] = 1'b1;
    #1;
    chk("mid_reset_outs", {v[2], dd[2], pe[2], fe[2], bk[2]}, 0);
    idle(3);
    rst_n[2] = 1'b1;
    idle(20 * P);
    chk("mid_reset_no_valid", nv[2], k);
    send(2, 9'h00A, 1'b0, 1'b1, 1'b1, 20, n);
    drain();
    chk("0a_after_reset", ld[2], 9'h00A);

    for (int id = 0; id < 3; id++) begin
      for (int j = 0; j < 10; j++) begin
        dat = 9'($urandom_range(0, 511));
        pb  = 1'($urandom_range(0, 1));
        s0  = $urandom_range(0, 4) != 0;
        s1  = $urandom_range(0, 4) != 0;
        if (j == 3) begin
          dat = '0;
          pb  = 1'b0;
          s0  = 1'b0;
          s1  = 1'b0;
        end
        last_stop = (nst(id) == 2) ? s1 : s0;
        gap = last_stop ? $urandom_range(0, 15) : $urandom_range(3, 15);
        send(id, dat, pb, s0, s1, gap, n);
      end
      idle(30);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
